// File: rtl/reg_file_pkg.sv
// Shared register-file defaults used by the register file, ALU and CPU top.
// No logic: parameters and a depth helper only.
// Not applicable (no handshake).
package reg_file_pkg;

  localparam int unsigned DATA_WIDTH_DEF = 8;
  localparam int unsigned ADDR_WIDTH_DEF = 3;
  localparam int unsigned RD_DELAY_DEF   = 2;
  localparam int unsigned WR_DELAY_DEF   = 2;

  // Number of registers addressed by an address of the given width.
  function automatic int unsigned depth(input int unsigned addr_width);
    return 32'd1 << addr_width;
  endfunction

endpackage

// File: rtl/reg_file_rdport.sv
// One read port: address decode, optional write bypass, optional hardwired-zero register 0.
// Latency: purely combinational from address, storage and write-port inputs.
// No backpressure: data and valid are always presented.
module reg_file_rdport
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter bit          ZERO_REG0  = 1'b0,
  parameter bit          BYPASS     = 1'b0
) (
  input  logic [ADDR_WIDTH-1:0]  i_addr,
  input  logic [DATA_WIDTH-1:0]  i_mem [depth(ADDR_WIDTH)],
  input  logic [depth(ADDR_WIDTH)-1:0] i_vld,
  input  logic                   i_rst,
  input  logic                   i_we0,
  input  logic [ADDR_WIDTH-1:0]  i_wa0,
  input  logic [DATA_WIDTH-1:0]  i_wd0,
  input  logic                   i_we1,
  input  logic [ADDR_WIDTH-1:0]  i_wa1,
  input  logic [DATA_WIDTH-1:0]  i_wd1,
  output logic [DATA_WIDTH-1:0]  o_dat,
  output logic                   o_vld
);

  logic w_hit0;
  logic w_hit1;
  logic w_is_zero;

  // A write only forwards when it will actually land at the coming edge, so reset blocks it.
  assign w_hit0    = i_we0 && !i_rst && (i_wa0 == i_addr);
  assign w_hit1    = i_we1 && !i_rst && (i_wa1 == i_addr);
  assign w_is_zero = (i_addr == '0);

  // Select stored entry, then forwarded write (port 1 last so it wins), then the zero override.
  always_comb begin
    o_dat = i_mem[i_addr];
    o_vld = i_vld[i_addr];
    if (BYPASS) begin
      if (w_hit0) begin
        o_dat = i_wd0;
        o_vld = 1'b1;
      end
      if (w_hit1) begin
        o_dat = i_wd1;
        o_vld = 1'b1;
      end
    end
    if (ZERO_REG0 && w_is_zero) begin
      o_dat = '0;
      o_vld = 1'b1;
    end
  end

endmodule

// File: rtl/reg_file_mp.sv
// Two-write, two-read register file with per-register valid scoreboard.
// Latency: writes land on the rising edge; reads are combinational (optionally bypassed).
// No backpressure: every write is accepted, every read is answered in the same cycle.
module reg_file_mp
  import reg_file_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int unsigned ADDR_WIDTH = ADDR_WIDTH_DEF,
  parameter bit          ZERO_REG0  = 1'b0,
  parameter bit          BYPASS     = 1'b0,
  parameter int unsigned RD_DELAY   = RD_DELAY_DEF,
  parameter int unsigned WR_DELAY   = WR_DELAY_DEF
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic                          WRITE0,
  input  logic [ADDR_WIDTH-1:0]         INADDRESS0,
  input  logic [DATA_WIDTH-1:0]         IN0,
  input  logic                          WRITE1,
  input  logic [ADDR_WIDTH-1:0]         INADDRESS1,
  input  logic [DATA_WIDTH-1:0]         IN1,
  input  logic [ADDR_WIDTH-1:0]         OUT1ADDRESS,
  input  logic [ADDR_WIDTH-1:0]         OUT2ADDRESS,
  output logic [DATA_WIDTH-1:0]         OUT1,
  output logic [DATA_WIDTH-1:0]         OUT2,
  output logic                          OUT1VALID,
  output logic                          OUT2VALID,
  output logic [depth(ADDR_WIDTH)-1:0]  VALIDMASK
);

  localparam int unsigned DEPTH = depth(ADDR_WIDTH);

  // RD_DELAY/WR_DELAY only shape the behavioural timing model; this
  // implementation settles within the cycle, which meets any non-negative delay.
  if (RD_DELAY > 1000 || WR_DELAY > 1000) begin : g_delay_range
    $error("reg_file_mp: RD_DELAY/WR_DELAY unreasonably large");
  end

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [DEPTH-1:0]      r_vld;
  logic                  w_wr0;
  logic                  w_wr1;

  // Register 0 is read-only when hardwired to zero; drop such writes before they reach storage.
  assign w_wr0 = WRITE0 && !(ZERO_REG0 && (INADDRESS0 == '0));
  assign w_wr1 = WRITE1 && !(ZERO_REG0 && (INADDRESS1 == '0));

  // Storage and valid update; reset beats writes, and port 1 is applied last so it wins a conflict.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
      r_vld <= {{(DEPTH-1){1'b0}}, ZERO_REG0};
    end else begin
      if (w_wr0) begin
        r_mem[INADDRESS0] <= IN0;
        r_vld[INADDRESS0] <= 1'b1;
      end
      if (w_wr1) begin
        r_mem[INADDRESS1] <= IN1;
        r_vld[INADDRESS1] <= 1'b1;
      end
    end
  end

  assign VALIDMASK = r_vld;

  reg_file_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG0  (ZERO_REG0),
    .BYPASS     (BYPASS)
  ) u_rd1 (
    .i_addr (OUT1ADDRESS),
    .i_mem  (r_mem),
    .i_vld  (r_vld),
    .i_rst  (RESET),
    .i_we0  (WRITE0),
    .i_wa0  (INADDRESS0),
    .i_wd0  (IN0),
    .i_we1  (WRITE1),
    .i_wa1  (INADDRESS1),
    .i_wd1  (IN1),
    .o_dat  (OUT1),
    .o_vld  (OUT1VALID)
  );

  reg_file_rdport #(
    .DATA_WIDTH (DATA_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .ZERO_REG0  (ZERO_REG0),
    .BYPASS     (BYPASS)
  ) u_rd2 (
    .i_addr (OUT2ADDRESS),
    .i_mem  (r_mem),
    .i_vld  (r_vld),
    .i_rst  (RESET),
    .i_we0  (WRITE0),
    .i_wa0  (INADDRESS0),
    .i_wd0  (IN0),
    .i_we1  (WRITE1),
    .i_wa1  (INADDRESS1),
    .i_wd1  (IN1),
    .o_dat  (OUT2),
    .o_vld  (OUT2VALID)
  );

endmodule

// File: tb/tb_reg_file_mp.sv
// Bench for reg_file_mp: two instances (8x8 plain; 16x16 with bypass and zero register)
// driven by shared directed-then-random stimulus, checked against an array model via a scoreboard.
module tb_reg_file_mp;

  logic        clk;
  logic        rst;
  logic        we0, we1;
  logic [3:0]  wa0, wa1, ra1, ra2;
  logic [15:0] wd0, wd1;

  logic [7:0]  a_o1, a_o2, a_vm;
  logic        a_v1, a_v2;
  logic [15:0] b_o1, b_o2, b_vm;
  logic        b_v1, b_v2;

  reg_file_mp #(.DATA_WIDTH(8), .ADDR_WIDTH(3), .ZERO_REG0(1'b0), .BYPASS(1'b0),
                .RD_DELAY(2), .WR_DELAY(2)) dut_a (
    .CLK(clk), .RESET(rst),
    .WRITE0(we0), .INADDRESS0(wa0[2:0]), .IN0(wd0[7:0]),
    .WRITE1(we1), .INADDRESS1(wa1[2:0]), .IN1(wd1[7:0]),
    .OUT1ADDRESS(ra1[2:0]), .OUT2ADDRESS(ra2[2:0]),
    .OUT1(a_o1), .OUT2(a_o2), .OUT1VALID(a_v1), .OUT2VALID(a_v2), .VALIDMASK(a_vm)
  );

  reg_file_mp #(.DATA_WIDTH(16), .ADDR_WIDTH(4), .ZERO_REG0(1'b1), .BYPASS(1'b1),
                .RD_DELAY(2), .WR_DELAY(2)) dut_b (
    .CLK(clk), .RESET(rst),
    .WRITE0(we0), .INADDRESS0(wa0), .IN0(wd0),
    .WRITE1(we1), .INADDRESS1(wa1), .IN1(wd1),
    .OUT1ADDRESS(ra1), .OUT2ADDRESS(ra2),
    .OUT1(b_o1), .OUT2(b_o2), .OUT1VALID(b_v1), .OUT2VALID(b_v2), .VALIDMASK(b_vm)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] a_o1, a_o2, a_vm;
    logic        a_v1, a_v2;
    logic [15:0] b_o1, b_o2, b_vm;
    logic        b_v1, b_v2;
  } exp_t;

  exp_t sb[$];
  int   n_total = 0;
  int   n_pass  = 0;

  // Reference model: plain arrays of register contents and valid flags.
  logic [7:0]  mem_a [8];
  logic        val_a [8];
  logic [15:0] mem_b [16];
  logic        val_b [16];

  // Apply what the clock edge does to the model, given the inputs held across it.
  task automatic model_edge();
    if (rst) begin
      for (int i = 0; i < 8; i++)  begin mem_a[i] = 8'h00;  val_a[i] = 1'b0; end
      for (int i = 0; i < 16; i++) begin mem_b[i] = 16'h0;  val_b[i] = (i == 0); end
    end else begin
      if (we0) begin mem_a[wa0[2:0]] = wd0[7:0]; val_a[wa0[2:0]] = 1'b1; end
      if (we1) begin mem_a[wa1[2:0]] = wd1[7:0]; val_a[wa1[2:0]] = 1'b1; end
      if (we0 && wa0 != 4'd0) begin mem_b[wa0] = wd0; val_b[wa0] = 1'b1; end
      if (we1 && wa1 != 4'd0) begin mem_b[wa1] = wd1; val_b[wa1] = 1'b1; end
    end
  endtask

  // Expected read for the bypassing, zero-register instance.
  task automatic read_b(input logic [3:0] ra, output logic [15:0] d, output logic v);
    if (ra == 4'd0) begin
      d = 16'h0; v = 1'b1;
    end else if (we1 && !rst && wa1 == ra) begin
      d = wd1; v = 1'b1;
    end else if (we0 && !rst && wa0 == ra) begin
      d = wd0; v = 1'b1;
    end else begin
      d = mem_b[ra]; v = val_b[ra];
    end
  endtask

  task automatic push_expect();
    exp_t e;
    e.a_o1 = {8'h00, mem_a[ra1[2:0]]};
    e.a_v1 = val_a[ra1[2:0]];
    e.a_o2 = {8'h00, mem_a[ra2[2:0]]};
    e.a_v2 = val_a[ra2[2:0]];
    e.a_vm = 16'h0;
    for (int i = 0; i < 8; i++) e.a_vm[i] = val_a[i];
    read_b(ra1, e.b_o1, e.b_v1);
    read_b(ra2, e.b_o2, e.b_v2);
    for (int i = 0; i < 16; i++) e.b_vm[i] = val_b[i];
    sb.push_back(e);
  endtask

  // Called at posedge+1: drive one cycle of inputs, record the expected pre-edge view, cross the edge.
  task automatic step(input logic r, input logic w0, input logic [3:0] a0, input logic [15:0] d0,
                      input logic w1, input logic [3:0] a1, input logic [15:0] d1,
                      input logic [3:0] q1, input logic [3:0] q2);
    rst = r; we0 = w0; wa0 = a0; wd0 = d0; we1 = w1; wa1 = a1; wd1 = d1; ra1 = q1; ra2 = q2;
    push_expect();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else n_pass++;
  endtask

  // Monitor: outputs are stable mid-cycle, so compare on the falling edge.
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      exp_t e;
      e = sb.pop_front();
      check("a_out1",  {8'h00, a_o1}, e.a_o1);
      check("a_out2",  {8'h00, a_o2}, e.a_o2);
      check("a_vld1",  {15'h0, a_v1}, {15'h0, e.a_v1});
      check("a_vld2",  {15'h0, a_v2}, {15'h0, e.a_v2});
      check("a_vmask", {8'h00, a_vm}, e.a_vm);
      check("b_out1",  b_o1, e.b_o1);
      check("b_out2",  b_o2, e.b_o2);
      check("b_vld1",  {15'h0, b_v1}, {15'h0, e.b_v1});
      check("b_vld2",  {15'h0, b_v2}, {15'h0, e.b_v2});
      check("b_vmask", b_vm, e.b_vm);
    end
  end

  initial begin
    logic       r, w0, w1;
    logic [3:0] a0, a1, q1, q2;
    int         left;
    rst = 1'b1; we0 = 1'b0; we1 = 1'b0; wa0 = 4'd0; wa1 = 4'd0;
    wd0 = 16'h0; wd1 = 16'h0; ra1 = 4'd0; ra2 = 4'd0;
    // Contents are unknown until the first reset edge, so nothing is expected before it.
    @(posedge clk);
    model_edge();
    #1;

    //   rst we0 wa0    wd0       we1 wa1    wd1       ra1    ra2
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd0,  4'd5);  // post-reset reads
    step(0, 1, 4'd3,  16'h00A5, 0, 4'd0,  16'h0000, 4'd3,  4'd5);  // write reg 3
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd3,  4'd3);  // read back reg 3
    step(0, 1, 4'd6,  16'h0011, 1, 4'd6,  16'h0022, 4'd6,  4'd1);  // conflict on reg 6
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd6,  4'd6);
    step(0, 1, 4'd2,  16'h0010, 0, 4'd0,  16'h0000, 4'd2,  4'd2);  // reg 2 = 10
    step(0, 0, 4'd0,  16'h0000, 1, 4'd2,  16'h0077, 4'd1,  4'd2);  // bypass vs old value
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd1,  4'd2);
    step(0, 1, 4'd2,  16'h0033, 1, 4'd2,  16'h0044, 4'd2,  4'd2);  // double bypass match
    step(0, 1, 4'd0,  16'hFFFF, 0, 4'd0,  16'h0000, 4'd0,  4'd0);  // write to reg 0
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd0,  4'd3);
    step(1, 1, 4'd4,  16'h003C, 0, 4'd0,  16'h0000, 4'd4,  4'd3);  // reset beats write
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd4,  4'd3);
    step(0, 0, 4'd0,  16'h0000, 1, 4'd15, 16'hBEEF, 4'd15, 4'd7);  // top register
    step(0, 0, 4'd0,  16'h0000, 0, 4'd0,  16'h0000, 4'd15, 4'd7);

    for (int n = 0; n < 600; n++) begin
      r  = ($urandom_range(0, 24) == 0);
      w0 = $urandom_range(0, 1) == 1;
      w1 = $urandom_range(0, 1) == 1;
      a0 = 4'($urandom);
      a1 = ($urandom_range(0, 3) == 0) ? a0 : 4'($urandom);
      q1 = ($urandom_range(0, 2) == 0) ? a0 : 4'($urandom);
      q2 = ($urandom_range(0, 2) == 0) ? a1 : 4'($urandom);
      step(r, w0, a0, 16'($urandom), w1, a1, 16'($urandom), q1, q2);
    end

    rst = 1'b0; we0 = 1'b0; we1 = 1'b0;
    left = 20;
    while (sb.size() > 0 && left > 0) begin
      @(posedge clk);
      left--;
    end
    check("sb_drain", 16'(sb.size()), 16'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-port register file for the single-cycle CPU datapath; next generation of the 8x8, 2-read/1-write file.
- Generalised in width and depth. Two write ports allow a future dual-issue or load-writeback path.
- Adds optional read-after-write bypass, optional hardwired-zero register 0, and a per-register valid scoreboard.
- Sits between decode (read addresses), writeback (write ports) and the ALU operand muxes.

Parameters:
- DATA_WIDTH, 8, bits per register.
- ADDR_WIDTH, 3, address bits; depth = 2**ADDR_WIDTH.
- ZERO_REG0, 0, when 1 register 0 always reads 0, is never written and is always valid.
- BYPASS, 0, when 1 a read of an address being written this cycle returns the write data.
- RD_DELAY, 2, simulation-only read-path delay in time units.
- WR_DELAY, 2, simulation-only delay from CLK posedge to register update.

Ports:
- CLK  input  1  clock; all state changes on the rising edge.
- RESET  input  1  synchronous, active-high reset.
- WRITE0  input  1  write enable, port 0.
- INADDRESS0  input  ADDR_WIDTH  write address, port 0.
- IN0  input  DATA_WIDTH  write data, port 0.
- WRITE1  input  1  write enable, port 1.
- INADDRESS1  input  ADDR_WIDTH  write address, port 1.
- IN1  input  DATA_WIDTH  write data, port 1.
- OUT1ADDRESS  input  ADDR_WIDTH  read address, port 1.
- OUT2ADDRESS  input  ADDR_WIDTH  read address, port 2.
- OUT1  output  DATA_WIDTH  read data, port 1.
- OUT2  output  DATA_WIDTH  read data, port 2.
- OUT1VALID  output  1  valid bit of the register addressed by OUT1ADDRESS.
- OUT2VALID  output  1  valid bit of the register addressed by OUT2ADDRESS.
- VALIDMASK  output  2**ADDR_WIDTH  all valid bits; bit i belongs to register i.

Behaviour:
- Reset:
  - Synchronous and active-high. On a posedge CLK with RESET=1, every register becomes 0 and every valid bit is cleared, except bit 0 when ZERO_REG0=1.
  - Writes in that cycle are ignored.
  - After the reset edge: OUT1, OUT2 = 0; OUT1VALID, OUT2VALID = 0 (or 1 when addressing reg 0 with ZERO_REG0=1); VALIDMASK = 0 (or 1 with ZERO_REG0=1).
  - RESET asserted mid-sequence overrides any pending write in the same edge. No reset effect occurs between edges.
- Write:
  - On posedge CLK with RESET=0, for each port with WRITEn=1: REG[INADDRESSn] <= INn and valid[INADDRESSn] <= 1, applied WR_DELAY after the edge.
  - Latency: the written value appears on a non-bypassed read WR_DELAY + RD_DELAY after the edge.
- Write conflict: WRITE0 and WRITE1 both set with equal addresses → port 1 wins (data and valid). Port 0's data is dropped; no error flag.
- Register 0 with ZERO_REG0=1: writes to address 0 are discarded and valid stays 1. Reads of address 0 return 0 regardless of bypass.
- Read:
  - Combinational from the address: OUTk = REG[OUTkADDRESS] after RD_DELAY, re-evaluated on any change of address or storage.
  - OUTkVALID follows the same path and delay.
- Bypass (BYPASS=1):
  - If WRITEn=1, RESET=0 and INADDRESSn == OUTkADDRESS, OUTk = INn and OUTkVALID = 1 combinationally (after RD_DELAY), before the edge.
  - Port 1 takes precedence over port 0 on a double match.
  - With BYPASS=0 the read shows the old contents until the edge.
- Both read ports may address the same register; both return identical data.
- Widths: no arithmetic. Addresses cover the full depth with no out-of-range case. Storage is uninitialised (X) until the first reset; X on the read outputs before the first reset is legal.

Decomposition:
- Shared package (reg_file_pkg): DATA_WIDTH and ADDR_WIDTH defaults, the depth function, and the RD_DELAY/WR_DELAY defaults shared with the ALU and CPU top.
- One natural sub-module: reg_file_rdport. Per read port it handles address decode, the ZERO_REG0 check and the bypass mux, returning data and valid. It is instantiated twice.

Test Plan:
1. Reset then read: RESET=1 for one edge; read addresses 0 and 5 → OUT1=OUT2=0, OUT1VALID=OUT2VALID=0, VALIDMASK=8'h00.
2. Basic write/read: write 8'hA5 to reg 3 via port 0; next cycle OUT1ADDRESS=3 → OUT1=8'hA5 and OUT1VALID=1 at edge+4; VALIDMASK=8'h08.
3. Write conflict: same edge WRITE0 (reg 6, 8'h11) and WRITE1 (reg 6, 8'h22) → reg 6 reads 8'h22.
4. Bypass: BYPASS=1, reg 2 holds 8'h10; WRITE1 reg 2 = 8'h77 with OUT2ADDRESS=2 before the edge → OUT2=8'h77 pre-edge. With BYPASS=0 → OUT2=8'h10 until the edge, then 8'h77.
5. Zero register: ZERO_REG0=1; write 8'hFF to reg 0 → OUT1 (addr 0) = 8'h00, OUT1VALID=1, VALIDMASK bit0=1.
6. Reset vs write: RESET=1 and WRITE0 (reg 4, 8'h3C) on the same edge → reg 4 = 0, valid[4] = 0. DATA_WIDTH=16/ADDR_WIDTH=4 rerun: write 16'hBEEF to reg 15 → readback 16'hBEEF.
